// File: rtl/majority_streak_tracker.sv
// Majority streak tracker: counts 0->1 transitions of an upstream 2-of-3
// vote, tracks the current run of 1 votes and raises a sticky alarm when the
// run reaches a programmable threshold. All outputs are registered.
module majority_streak_tracker #(
  parameter int CNT_W = 8,
  parameter int STK_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  input  logic             in_vote,
  input  logic             clear,
  input  logic [STK_W-1:0] thresh,
  output logic             out_val,
  output logic [CNT_W-1:0] events,
  output logic [STK_W-1:0] streak,
  output logic             alarm,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] EV_MAX  = '1;
  localparam logic [STK_W-1:0] STK_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] events_q, events_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             alarm_q, alarm_d;
  logic             out_val_q, out_val_d;

  // State and output registers; reset forces everything to the idle picture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      events_q  <= '0;
      streak_q  <= '0;
      alarm_q   <= 1'b0;
      out_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      events_q  <= events_d;
      streak_q  <= streak_d;
      alarm_q   <= alarm_d;
      out_val_q <= out_val_d;
    end
  end

  // Next-state: an accepted sample moves to HIGH/LOW from any legal state;
  // the unused encoding always falls back to IDLE, even if a sample arrives.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LOW, HIGH: if (in_val) state_d = in_vote ? HIGH : LOW;
        default:         state_d = IDLE;
      endcase
    end
  end

  // Counters and alarm: only accepted samples change them; clear wins.
  always_comb begin
    events_d  = events_q;
    streak_d  = streak_q;
    alarm_d   = alarm_q;
    out_val_d = 1'b0;
    if (clear) begin
      events_d = '0;
      streak_d = '0;
      alarm_d  = 1'b0;
    end else if (in_val) begin
      out_val_d = 1'b1;
      if (in_vote) begin
        // A rising vote is any 1 not preceded by a 1 (IDLE counts as 0).
        if (state_q != HIGH && events_q != EV_MAX)
          events_d = events_q + 1'b1;
        if (streak_q != STK_MAX)
          streak_d = streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
      // Compare the updated streak against this cycle's threshold.
      if (thresh != '0 && streak_d >= thresh)
        alarm_d = 1'b1;
    end
  end

  assign out_val = out_val_q;
  assign events  = events_q;
  assign streak  = streak_q;
  assign alarm   = alarm_q;
  assign state   = state_q;

endmodule

// File: tb/tb_majority_streak_tracker.sv
// Scoreboard bench for majority_streak_tracker: each accepted sample pushes
// its hand-computed expected outputs; a monitor pops on every out_val.
module tb_majority_streak_tracker;

  localparam int CNT_W = 8;
  localparam int STK_W = 4;
  localparam logic [1:0] S_IDLE = 2'b00, S_LOW = 2'b01, S_HIGH = 2'b10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_val, in_vote, clear;
  logic [STK_W-1:0] thresh;
  logic             out_val;
  logic [CNT_W-1:0] events;
  logic [STK_W-1:0] streak;
  logic             alarm;
  logic [1:0]       state;

  typedef struct packed {
    logic [CNT_W-1:0] ev;
    logic [STK_W-1:0] st;
    logic             al;
    logic [1:0]       sm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  majority_streak_tracker #(.CNT_W(CNT_W), .STK_W(STK_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_vote(in_vote),
    .clear(clear), .thresh(thresh), .out_val(out_val), .events(events),
    .streak(streak), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every out_val pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_val) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_val", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("events", int'(events), int'(e.ev));
        check("streak", int'(streak), int'(e.st));
        check("alarm",  int'(alarm),  int'(e.al));
        check("state",  int'(state),  int'(e.sm));
      end
    end
  end

  // Issue one accepted sample and queue what the outputs should become.
  task automatic send(input logic v, input int thr, input int ev, input int st,
                      input logic al, input logic [1:0] sm);
    exp_t e;
    in_val  = 1'b1;
    in_vote = v;
    thresh  = STK_W'(thr);
    e.ev = CNT_W'(ev); e.st = STK_W'(st); e.al = al; e.sm = sm;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic check_all(input string tag, input int ev, input int st,
                           input int al, input int sm, input int ov);
    check({tag, "_events"},  int'(events),  ev);
    check({tag, "_streak"},  int'(streak),  st);
    check({tag, "_alarm"},   int'(alarm),   al);
    check({tag, "_state"},   int'(state),   sm);
    check({tag, "_out_val"}, int'(out_val), ov);
  endtask

  // Clear (optionally with a competing sample) and confirm all zeros.
  task automatic do_clear(input logic with_sample);
    clear   = 1'b1;
    in_val  = with_sample;
    in_vote = 1'b1;
    @(posedge clk); #1;
    clear  = 1'b0;
    in_val = 1'b0;
    check_all("clear", 0, 0, 0, 0, 0);
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_val = 1'b0; in_vote = 1'b0; clear = 1'b0; thresh = '0;
    #23;
    check_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Votes 1,1,0,1 with alarm disabled.
    send(1, 0, 1, 1, 0, S_HIGH);
    send(1, 0, 1, 2, 0, S_HIGH);
    send(0, 0, 1, 0, 0, S_LOW);
    send(1, 0, 2, 1, 0, S_HIGH);
    drain();

    // Threshold 3: alarm on the third 1, sticky after the run ends.
    do_clear(1'b0);
    send(1, 3, 1, 1, 0, S_HIGH);
    send(1, 3, 1, 2, 0, S_HIGH);
    send(1, 3, 1, 3, 1, S_HIGH);
    send(0, 3, 1, 0, 1, S_LOW);
    send(1, 0, 2, 1, 1, S_HIGH);
    drain();

    // in_vote toggling with in_val low changes nothing.
    for (int i = 0; i < 10; i++) begin
      in_vote = i[0];
      @(posedge clk); #1;
    end
    check_all("hold", 2, 1, 1, S_HIGH, 0);

    // Build events=5, then clear collides with an accepted sample.
    do_clear(1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) send(1, 0, i / 2 + 1, 1, 0, S_HIGH);
      else            send(0, 0, i / 2 + 1, 0, 0, S_LOW);
    end
    drain();
    check("events_before_clear", int'(events), 5);
    do_clear(1'b1);

    // Streak saturation: 20 ones.
    for (int i = 0; i < 20; i++)
      send(1, 0, 1, (i + 1 > 15) ? 15 : i + 1, 0, S_HIGH);
    // Events saturation: alternating 0/1 long enough to pass 255 rises.
    for (int i = 0; i < 520; i++) begin
      int ev;
      ev = 1 + (i + 1) / 2;
      if (ev > 255) ev = 255;
      if (i % 2 == 0) send(0, 0, ev, 0, 0, S_LOW);
      else            send(1, 0, ev, 1, 0, S_HIGH);
    end
    drain();

    // Threshold at the streak maximum.
    do_clear(1'b0);
    for (int i = 0; i < 15; i++)
      send(1, 15, 1, i + 1, (i == 14), S_HIGH);
    drain();

    // Asynchronous reset mid-run with state HIGH, streak 7.
    do_clear(1'b0);
    for (int i = 0; i < 7; i++)
      send(1, 0, 1, i + 1, 0, S_HIGH);
    drain();
    check("streak_before_reset", int'(streak), 7);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    send(1, 0, 1, 1, 0, S_HIGH);
    drain();

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
